// File: rtl/tick_meter_pkg.sv
// ---------------------------------------------------------------------------
// tick_meter_pkg
// Shared types and constants for the tick period meter.
//   meter_state_t : measurement phase (IDLE / ARMED / RUN)
//   DEFAULT_WIDTH : default width of the interval counter and recovered period
// ---------------------------------------------------------------------------
package tick_meter_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } meter_state_t;

endpackage : tick_meter_pkg

// File: rtl/tick_interval_counter.sv
// ---------------------------------------------------------------------------
// tick_interval_counter
// Counts enabled non-tick cycles between tick events. The owner decides when
// to clear and when to increment; this block only holds the count and flags
// when it sits at its all-ones value so the owner can declare overflow
// instead of letting the count wrap.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears the count
//   clr    : synchronous clear (priority over inc)
//   inc    : advance the count by one
//   cnt    : current count
//   at_max : count equals 2^WIDTH-1
// ---------------------------------------------------------------------------
module tick_interval_counter
    import tick_meter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_r;

    // Interval count register: reset, clear, increment or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt    = cnt_r;
    assign at_max = (cnt_r == CNT_MAX);

endmodule : tick_interval_counter

// File: rtl/tick_period_meter.sv
// ---------------------------------------------------------------------------
// tick_period_meter
// Recovers the divide value N of a tick stream by counting enabled non-tick
// cycles between consecutive enabled tick cycles.
// Optional build macro: TICK_PERIOD_METER_CHECK_EN adds an expected-period
// input and a mismatch pulse output.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (priority over everything)
//   en       : cycle enable; tick_in sampled and counter advances only when 1
//   tick_in  : tick stream, level-sampled on enabled cycles
//   period   : last recovered N
//   valid    : one-cycle strobe, period updated this cycle
//   locked   : last two measured periods equal
//   overflow : sticky, an interval exceeded 2^WIDTH-1 enabled cycles
//   expected : (macro only) reference period, sampled with the tick
//   mismatch : (macro only) pulse alongside valid when period != expected
// ---------------------------------------------------------------------------
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick_in,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             locked,
    output logic             overflow
`ifdef TICK_PERIOD_METER_CHECK_EN
    ,
    input  logic [WIDTH-1:0] expected,
    output logic             mismatch
`endif
);

    meter_state_t     state_r;
    meter_state_t     state_nxt_s;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] period_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic             locked_r;
    logic             locked_nxt_s;
    logic             overflow_r;
    logic             overflow_nxt_s;
    logic             cnt_clr_s;
    logic             cnt_inc_s;
    logic [WIDTH-1:0] cnt_s;
    logic             cnt_at_max_s;
    logic             measure_s;

    tick_interval_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_s),
        .inc    (cnt_inc_s),
        .cnt    (cnt_s),
        .at_max (cnt_at_max_s)
    );

    // Next-state and next-output decode for the measurement FSM.
    always_comb begin
        state_nxt_s    = state_r;
        period_nxt_s   = period_r;
        valid_nxt_s    = 1'b0;
        locked_nxt_s   = locked_r;
        overflow_nxt_s = overflow_r;
        cnt_clr_s      = 1'b0;
        cnt_inc_s      = 1'b0;
        measure_s      = 1'b0;

        if (en) begin
            case (state_r)
                IDLE: begin
                    if (tick_in) begin
                        cnt_clr_s   = 1'b1;
                        state_nxt_s = ARMED;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ARMED, RUN: begin
                    if (tick_in) begin
                        // A tick on the cycle the count is all-ones is still a
                        // legal measurement, so tick is tested before at_max.
                        measure_s    = 1'b1;
                        period_nxt_s = cnt_s;
                        valid_nxt_s  = 1'b1;
                        cnt_clr_s    = 1'b1;
                        state_nxt_s  = RUN;
                        // period_r still holds the previous measurement here.
                        locked_nxt_s = (state_r == RUN) && (cnt_s == period_r);
                    end else if (cnt_at_max_s) begin
                        overflow_nxt_s = 1'b1;
                        locked_nxt_s   = 1'b0;
                        cnt_clr_s      = 1'b1;
                        state_nxt_s    = IDLE;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
                default: begin
                    cnt_clr_s    = 1'b1;
                    locked_nxt_s = 1'b0;
                    state_nxt_s  = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered measurement outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_r   <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            locked_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            period_r   <= period_nxt_s;
            valid_r    <= valid_nxt_s;
            locked_r   <= locked_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    assign period   = period_r;
    assign valid    = valid_r;
    assign locked   = locked_r;
    assign overflow = overflow_r;

`ifdef TICK_PERIOD_METER_CHECK_EN
    logic mismatch_r;

    // Period comparator, registered in step with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_r <= 1'b0;
        end else if (measure_s) begin
            mismatch_r <= (cnt_s != expected);
        end else begin
            mismatch_r <= 1'b0;
        end
    end

    assign mismatch = mismatch_r;
`else
    // measure_s only feeds the optional comparator.
    logic unused_measure_s;
    assign unused_measure_s = measure_s;
`endif

endmodule : tick_period_meter

// File: tb/tb_tick_period_meter.sv
// ---------------------------------------------------------------------------
// tb_tick_period_meter
// Drives a WIDTH=16 and a WIDTH=4 meter from the same stimulus. A model based
// on the enabled-cycle index of each tick event predicts every output; a
// negedge process compares both DUTs against it on every cycle. Directed
// sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_tick_period_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tick_in;
    logic [15:0] expected;

    logic [15:0] period16;
    logic        valid16, locked16, overflow16;
    logic [3:0]  period4;
    logic        valid4, locked4, overflow4;
`ifdef TICK_PERIOD_METER_CHECK_EN
    logic        mismatch16, mismatch4;
`endif

    always #5 clk = ~clk;

    tick_period_meter #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .en(en), .tick_in(tick_in),
        .period(period16), .valid(valid16), .locked(locked16), .overflow(overflow16)
`ifdef TICK_PERIOD_METER_CHECK_EN
        , .expected(expected), .mismatch(mismatch16)
`endif
    );

    tick_period_meter #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .tick_in(tick_in),
        .period(period4), .valid(valid4), .locked(locked4), .overflow(overflow4)
`ifdef TICK_PERIOD_METER_CHECK_EN
        , .expected(expected[3:0]), .mismatch(mismatch4)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models WIDTH=16, index 1 models WIDTH=4.
    int ecount;
    int m_max    [2] = '{65535, 15};
    int have_ref [2];
    int last_idx [2];
    int nmeas    [2];
    int m_period [2];
    int m_valid  [2];
    int m_locked [2];
    int m_ovf    [2];
    int m_mis    [2];

    always @(posedge clk) begin
        if (rst) begin
            ecount = 0;
            for (int i = 0; i < 2; i++) begin
                have_ref[i] = 0; last_idx[i] = 0; nmeas[i] = 0;
                m_period[i] = 0; m_valid[i] = 0; m_locked[i] = 0;
                m_ovf[i] = 0; m_mis[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 0;
                m_mis[i]   = 0;
            end
            if (en) begin
                for (int i = 0; i < 2; i++) begin
                    int gap;
                    gap = ecount - last_idx[i] - 1;
                    if (tick_in) begin
                        if (have_ref[i] != 0) begin
                            m_locked[i] = (nmeas[i] >= 1 && gap == m_period[i]) ? 1 : 0;
                            m_period[i] = gap;
                            m_valid[i]  = 1;
                            m_mis[i]    = (gap != (int'(expected) % (m_max[i] + 1))) ? 1 : 0;
                            nmeas[i]++;
                        end
                        have_ref[i] = 1;
                        last_idx[i] = ecount;
                    end else if (have_ref[i] != 0 && gap == m_max[i]) begin
                        m_ovf[i]    = 1;
                        m_locked[i] = 0;
                        have_ref[i] = 0;
                        nmeas[i]    = 0;
                    end
                end
                ecount++;
            end
        end
    end

    // Cycle-by-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("u16_period",   period16,   m_period[0]);
            check("u16_valid",    valid16,    m_valid[0]);
            check("u16_locked",   locked16,   m_locked[0]);
            check("u16_overflow", overflow16, m_ovf[0]);
            check("u4_period",    period4,    m_period[1]);
            check("u4_valid",     valid4,     m_valid[1]);
            check("u4_locked",    locked4,    m_locked[1]);
            check("u4_overflow",  overflow4,  m_ovf[1]);
`ifdef TICK_PERIOD_METER_CHECK_EN
            check("u16_mismatch", mismatch16, m_mis[0]);
            check("u4_mismatch",  mismatch4,  m_mis[1]);
`endif
        end
    end

    // Apply inputs just after a negedge, return at the next negedge so the
    // outputs then reflect the edge that sampled these inputs.
    task automatic step(input logic r, input logic e, input logic t);
        rst = r; en = e; tick_in = t;
        @(negedge clk);
    endtask

    task automatic interval(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int p;
        rst = 1'b1; en = 1'b0; tick_in = 1'b0; expected = 16'd4;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0);
        chk_en = 1'b1;

        // Reset state
        check("rst_period", period16, 0);
        check("rst_valid", valid16, 0);
        check("rst_locked", locked16, 0);
        check("rst_overflow", overflow16, 0);

        // N=4, en constant
        step(1'b0, 1'b1, 1'b1);
        check("n4_first_tick_valid", valid16, 0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        check("n4_no_early_valid", valid16, 0);
        step(1'b0, 1'b1, 1'b1);
        check("n4_m1_valid", valid16, 1);
        check("n4_m1_period", period16, 4);
        check("n4_m1_locked", locked16, 0);
`ifdef TICK_PERIOD_METER_CHECK_EN
        check("n4_m1_mismatch", mismatch16, 0);
`endif
        step(1'b0, 1'b1, 1'b0);
        check("n4_valid_one_cycle", valid16, 0);
        interval(3);
        check("n4_m2_period", period16, 4);
        check("n4_m2_locked", locked16, 1);
        check("n4_overflow", overflow16, 0);
`ifdef TICK_PERIOD_METER_CHECK_EN
        interval(5);
        check("chk_m3_valid", valid16, 1);
        check("chk_m3_mismatch", mismatch16, 1);
        step(1'b0, 1'b1, 1'b0);
        check("chk_mismatch_one_cycle", mismatch16, 0);
`endif

        // N=0, tick held high
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("n0_first_no_valid", valid16, 0);
        step(1'b0, 1'b1, 1'b1);
        check("n0_valid", valid16, 1);
        check("n0_period", period16, 0);
        step(1'b0, 1'b1, 1'b1);
        check("n0_locked", locked16, 1);

        // N=3 with en toggling
        step(1'b1, 1'b0, 1'b0);
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b0, 1'b1, (k == 0) ? 1'b1 : 1'b0);
                step(1'b0, 1'b0, 1'b1);
                check("n3_no_valid_en0", valid16, 0);
            end
        end
        step(1'b0, 1'b1, 1'b1);
        check("n3_period", period16, 3);
        check("n3_locked", locked16, 1);

        // WIDTH=4 overflow
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        interval(2);
        check("w4_pre_period", period4, 2);
        repeat (15) step(1'b0, 1'b1, 1'b0);
        check("w4_no_ovf_at_15", overflow4, 0);
        step(1'b0, 1'b1, 1'b0);
        check("w4_ovf", overflow4, 1);
        check("w4_ovf_locked", locked4, 0);
        check("w4_ovf_period", period4, 2);
        step(1'b0, 1'b1, 1'b1);
        check("w4_rearm_no_valid", valid4, 0);
        interval(6);
        check("w4_resume_period", period4, 6);
        check("w4_resume_valid", valid4, 1);
        check("w4_ovf_sticky", overflow4, 1);

        // Lock loss then reset mid-interval
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        interval(4);
        interval(4);
        check("ll_locked", locked16, 1);
        interval(2);
        check("ll_unlocked", locked16, 0);
        check("ll_period", period16, 2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("mid_rst_period", period16, 0);
        check("mid_rst_locked", locked16, 0);
        step(1'b0, 1'b1, 1'b1);
        check("post_rst_no_valid", valid16, 0);
        interval(1);
        check("post_rst_period", period16, 1);

        // Randomized run
        p = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: p = 100;
                    1: p = 30;
                    2: p = 12;
                    default: p = 4;
                endcase
            end
            expected = 16'($urandom_range(2, 6));
            step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < p) ? 1'b1 : 1'b0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tick_period_meter
